pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. Tracks outstanding instruction-fetch and data-memory bus transactions and the multi-cycle divider. Produces the 4-bit stall vector consumed by every inter-stage pipeline register, plus the flush strobe. Sits beside the pipeline registers, between the SRAM-like bus bridge and the stage logic.

Parameters:
DIV_CYCLES, 33, total divider latency in cycles including the start cycle; legal range 2..64.
CNT_W, 6, width of the divider countdown counter; must satisfy 2^CNT_W >= DIV_CYCLES.

Ports:
clock_i  in  1  sole clock, rising edge
reset_i  in  1  asynchronous reset, active-low
inst_req_i  in  1  fetch stage issues an instruction read this cycle
inst_ok_i  in  1  instruction bus returns data this cycle
inst_req_ready_o  out  1  controller can accept a new fetch request
inst_discard_o  out  1  the current inst_ok_i return belongs to a flushed fetch; drop it
data_req_i  in  1  MEM stage issues a load/store this cycle
data_ok_i  in  1  data bus completes this cycle
load_use_i  in  1  ID detects a load-use hazard (combinational)
div_start_i  in  1  EXE starts a divide this cycle
exception_i  in  1  exception/eret committed this cycle
stall_o  out  4  [0] inst, [1] id, [2] exe, [3] data
flush_o  out  1  flush all pipeline registers
div_busy_o  out  1  divider countdown active

Behaviour:
- Reset (reset_i=0, asynchronous): inst FSM=I_IDLE, data FSM=D_IDLE, div counter=0. All outputs 0 except inst_req_ready_o=1.
- Inst FSM states: I_IDLE, I_WAIT, I_DISCARD.
  - I_IDLE: inst_req_i & ~inst_ok_i -> I_WAIT. inst_req_i & inst_ok_i (zero-wait return) stays in I_IDLE.
  - I_WAIT: inst_ok_i -> I_IDLE, with priority over exception_i in the same cycle. exception_i & ~inst_ok_i -> I_DISCARD.
  - I_DISCARD: inst_ok_i -> I_IDLE with inst_discard_o=1 that cycle. exception_i has no further effect.
  - inst_req_i is ignored outside I_IDLE.
  - inst_req_ready_o = (state==I_IDLE).
- stall_o[0] = (I_IDLE & inst_req_i & ~inst_ok_i) | (I_WAIT & ~inst_ok_i) | I_DISCARD.
- Data FSM states: D_IDLE, D_WAIT.
  - D_IDLE: data_req_i & ~data_ok_i -> D_WAIT.
  - D_WAIT: data_ok_i -> D_IDLE.
  - exception_i never cancels a data transaction; stores must complete.
- stall_o[3] = (D_IDLE & data_req_i & ~data_ok_i) | (D_WAIT & ~data_ok_i).
- Divider: div_start_i with counter==0 loads DIV_CYCLES-1. Counter decrements while nonzero.
  - div_start_i while counter!=0 is ignored.
  - exception_i clears the counter to 0 on the same edge and takes priority over div_start_i.
  - div_busy_o = (counter!=0). stall_o[2] = div_busy_o | (div_start_i & counter==0 & ~exception_i).
- stall_o[1] = load_use_i & ~exception_i. All stall bits are raw and un-cascaded; pipeline registers combine them.
- flush_o = exception_i, combinational, same cycle.
- All stall/ready/discard outputs are combinational from state and inputs. No added latency.
- FSM updates occur on the rising edge. Reset mid-transaction returns to idle immediately; any late inst_ok_i/data_ok_i arriving in idle is treated as a zero-wait completion of nothing (no state change, no discard).

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- When defined: adds output perf_stall_cnt_o[31:0], counting cycles where |stall_o is 1. The counter wraps at 2^32, resets to 0, and is not cleared by exception_i.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Fetch wait: inst_req_i=1 cycle 0, inst_ok_i=1 cycle 3 -> stall_o[0]=1 cycles 0–2, 0 at cycle 3; inst_req_ready_o=0 cycles 1–3.
- Fetch flush: inst_req_i cycle 0, exception_i cycle 1, inst_ok_i cycle 4 -> flush_o=1 cycle 1; inst_discard_o=1 only cycle 4; inst_req_ready_o=1 cycle 5.
- Same-cycle: I_WAIT with inst_ok_i=1 and exception_i=1 -> next state I_IDLE, inst_discard_o=0.
- Divider: DIV_CYCLES=33, div_start_i cycle 0 -> stall_o[2]=1 cycles 0–32, 0 at 33. A second div_start_i at cycle 5 is ignored. exception_i at cycle 10 -> stall_o[2]=0 from cycle 11.
- Store across exception: data_req_i cycle 0, exception_i cycle 1, data_ok_i cycle 3 -> stall_o[3]=1 cycles 0–2, D_WAIT held through cycle 2.
- Async reset in I_WAIT/D_WAIT, mid-cycle -> all stall_o=0 immediately; inst_req_ready_o=1; with STALL_PERF_CNT_EN, perf_stall_cnt_o=0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: fetch/data bus trackers, divider countdown.
// Optional STALL_PERF_CNT_EN adds a free-running count of stalled cycles.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        inst_req_i,
  input  logic        inst_ok_i,
  output logic        inst_req_ready_o,
  output logic        inst_discard_o,
  input  logic        data_req_i,
  input  logic        data_ok_i,
  input  logic        load_use_i,
  input  logic        div_start_i,
  input  logic        exception_i,
  output logic [3:0]  stall_o,
  output logic        flush_o,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt_o,
`endif
  output logic        div_busy_o
);

  typedef enum logic [1:0] {I_IDLE, I_WAIT, I_DISCARD} inst_state_t;
  typedef enum logic {D_IDLE, D_WAIT} data_state_t;

  inst_state_t      inst_st;
  data_state_t      data_st;
  logic [CNT_W-1:0] div_cnt;
  logic             div_load;

  // A fetch killed by an exception must still be drained from the bus, then dropped.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      inst_st <= I_IDLE;
    end else begin
      case (inst_st)
        I_IDLE:    if (inst_req_i && !inst_ok_i) inst_st <= I_WAIT;
        I_WAIT: begin
          if (inst_ok_i)        inst_st <= I_IDLE;
          else if (exception_i) inst_st <= I_DISCARD;
        end
        I_DISCARD: if (inst_ok_i) inst_st <= I_IDLE;
        default:   inst_st <= I_IDLE;
      endcase
    end
  end

  // Stores already on the bus are never cancelled by an exception.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      data_st <= D_IDLE;
    end else begin
      case (data_st)
        D_IDLE:  if (data_req_i && !data_ok_i) data_st <= D_WAIT;
        D_WAIT:  if (data_ok_i) data_st <= D_IDLE;
        default: data_st <= D_IDLE;
      endcase
    end
  end

  assign div_load = div_start_i && (div_cnt == '0) && !exception_i;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      div_cnt <= '0;
    end else if (exception_i) begin
      div_cnt <= '0;
    end else if (div_cnt != '0) begin
      div_cnt <= div_cnt - 1'b1;
    end else if (div_load) begin
      div_cnt <= CNT_W'(DIV_CYCLES - 1);
    end
  end

  always_comb begin
    inst_req_ready_o = (inst_st == I_IDLE);
    inst_discard_o   = (inst_st == I_DISCARD) && inst_ok_i;
    div_busy_o       = (div_cnt != '0);
    flush_o          = exception_i;
    stall_o[0] = ((inst_st == I_IDLE) && inst_req_i && !inst_ok_i) ||
                 ((inst_st == I_WAIT) && !inst_ok_i) ||
                 (inst_st == I_DISCARD);
    stall_o[1] = load_use_i && !exception_i;
    stall_o[2] = div_busy_o || div_load;
    stall_o[3] = ((data_st == D_IDLE) && data_req_i && !data_ok_i) ||
                 ((data_st == D_WAIT) && !data_ok_i);
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i)      perf_cnt <= '0;
    else if (|stall_o) perf_cnt <= perf_cnt + 32'd1;
  end

  assign perf_stall_cnt_o = perf_cnt;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed per-cycle vectors, checked by a negedge monitor.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ireq = 0, iok = 0, dreq = 0, dok = 0, lu = 0, ds = 0, exc = 0;
  logic       rdy, disc, flush, busy;
  logic [3:0] stall;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      nm;
    logic [7:0] v;   // {stall[3:0], ready, discard, flush, busy}
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_CYCLES(33), .CNT_W(6)) dut (
    .clock_i          (clk),
    .reset_i          (rst_n),
    .inst_req_i       (ireq),
    .inst_ok_i        (iok),
    .inst_req_ready_o (rdy),
    .inst_discard_o   (disc),
    .data_req_i       (dreq),
    .data_ok_i        (dok),
    .load_use_i       (lu),
    .div_start_i      (ds),
    .exception_i      (exc),
    .stall_o          (stall),
    .flush_o          (flush),
`ifdef STALL_PERF_CNT_EN
    .perf_stall_cnt_o (perf),
`endif
    .div_busy_o       (busy)
  );

  // Monitor: outputs are combinational each cycle, so compare once per cycle mid-period.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = q.pop_front();
      act = {stall, rdy, disc, flush, busy};
      n_tests++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got stall=%b rdy=%b disc=%b flush=%b busy=%b, want stall=%b rdy=%b disc=%b flush=%b busy=%b",
                 e.nm, act[7:4], act[3], act[2], act[1], act[0],
                 e.v[7:4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  // in = {ireq, iok, dreq, dok, lu, ds, exc}; ex = {stall[3:0], ready, discard, flush, busy}
  task automatic cyc(input string nm, input logic [6:0] in, input logic [7:0] ex);
    exp_t e;
    @(posedge clk);
    #1;
    {ireq, iok, dreq, dok, lu, ds, exc} = in;
    e.nm = nm;
    e.v  = ex;
    q.push_back(e);
  endtask

  initial begin
    // Reset state
    cyc("reset", 7'b0000000, 8'b0000_1000);
    #1 rst_n = 1'b1;

    // Fetch wait: req c0, ok c3
    cyc("fw_c0", 7'b1000000, 8'b0001_1000);
    cyc("fw_c1", 7'b0000000, 8'b0001_0000);
    cyc("fw_c2", 7'b0000000, 8'b0001_0000);
    cyc("fw_c3", 7'b0100000, 8'b0000_0000);
    cyc("fw_c4", 7'b0000000, 8'b0000_1000);

    // Fetch flush: req c0, exception c1, ok c4
    cyc("ff_c0", 7'b1000000, 8'b0001_1000);
    cyc("ff_c1", 7'b0000001, 8'b0001_0010);
    cyc("ff_c2", 7'b0000000, 8'b0001_0000);
    cyc("ff_c3", 7'b1000000, 8'b0001_0000);
    cyc("ff_c4", 7'b0100000, 8'b0001_0100);
    cyc("ff_c5", 7'b0000000, 8'b0000_1000);

    // ok and exception together in I_WAIT; then stray ok and zero-wait fetch in idle
    cyc("sc_c0", 7'b1000000, 8'b0001_1000);
    cyc("sc_c1", 7'b0100001, 8'b0000_0010);
    cyc("sc_c2", 7'b0100000, 8'b0000_1000);
    cyc("sc_c3", 7'b1100000, 8'b0000_1000);
    cyc("sc_c4", 7'b0000000, 8'b0000_1000);

    // Store across exception: req c0, exception c1, ok c3; then zero-wait access
    cyc("st_c0", 7'b0010000, 8'b1000_1000);
    cyc("st_c1", 7'b0000001, 8'b1000_1010);
    cyc("st_c2", 7'b0000000, 8'b1000_1000);
    cyc("st_c3", 7'b0001000, 8'b0000_1000);
    cyc("st_c4", 7'b0011000, 8'b0000_1000);
    cyc("st_c5", 7'b0000000, 8'b0000_1000);

    // Load-use, masked by exception
    cyc("lu",     7'b0000100, 8'b0010_1000);
    cyc("lu_exc", 7'b0000101, 8'b0000_1010);

    // Divider start suppressed by a simultaneous exception
    cyc("dx_c0", 7'b0000011, 8'b0000_1010);
    cyc("dx_c1", 7'b0000000, 8'b0000_1000);

    // Full divide, second start at c5 ignored: stall c0..c32, busy c1..c32
    for (int i = 0; i <= 34; i++) begin
      logic s2, b;
      s2 = (i <= 32);
      b  = (i >= 1) && (i <= 32);
      cyc($sformatf("div_c%0d", i), {5'b00000, (i == 0 || i == 5), 1'b0},
          {1'b0, s2, 2'b00, 1'b1, 1'b0, 1'b0, b});
    end

    // Divide killed by exception at c10
    for (int i = 0; i <= 12; i++) begin
      logic s2, b;
      s2 = (i <= 10);
      b  = (i >= 1) && (i <= 10);
      cyc($sformatf("divx_c%0d", i), {5'b00000, (i == 0), (i == 10)},
          {1'b0, s2, 2'b00, 1'b1, 1'b0, (i == 10), b});
    end

    // Async reset mid-cycle with fetch and data both waiting
    cyc("ar_c0", 7'b1010000, 8'b1001_1000);
    cyc("ar_c1", 7'b0000000, 8'b1001_0000);
    cyc("ar_c2", 7'b0000000, 8'b0000_1000);
    #2 rst_n = 1'b0;
`ifdef STALL_PERF_CNT_EN
    #1;
    n_tests++;
    if (perf !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset: got %0d, want 0", perf);
    end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("ar_post", 7'b0000000, 8'b0000_1000);

    @(posedge clk);
    #6;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
